// File: rtl/cic_interp.sv
// N-stage CIC interpolator: input-rate comb chain, zero-stuff by R,
// output-rate integrator chain. Build option: CIC_INTERP_NORM_EN.
// Ports: clk, rst (async, active-low), clk_en (output-rate tick),
//   in_data/in_valid/in_ready (sample handshake, accepted on phase 0),
//   out_data/out_valid (integrator output, pulse after each tick),
//   underrun/underrun_clr (sticky missed-sample flag and its clear).
module cic_interp #(
  parameter int WIDTH  = 16,
  parameter int R      = 100,
  parameter int M      = 1,
  parameter int N      = 3,
  parameter int GROWTH = N * $clog2(R * M),
  parameter int OUT_W  = WIDTH + GROWTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
`ifdef CIC_INTERP_NORM_EN
  output logic [WIDTH-1:0] out_data,
`else
  output logic [OUT_W-1:0] out_data,
`endif
  output logic             out_valid,
  output logic             underrun,
  input  logic             underrun_clr
);

  localparam int PW = $clog2(R);

  logic [PW-1:0] phase;
  logic          slot;
  logic          take;

  logic [WIDTH-1:0] hold;
  logic [WIDTH-1:0] xs;

  logic signed [OUT_W-1:0] cin   [N+1];
  logic signed [OUT_W-1:0] dly   [N][M];
  logic signed [OUT_W-1:0] u;
  logic signed [OUT_W-1:0] integ [N];
  logic signed [OUT_W-1:0] nxt   [N];

  assign slot     = clk_en && (phase == '0);
  assign take     = slot && in_valid;
  assign in_ready = slot && rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase <= '0;
    end else if (clk_en) begin
      if (phase == PW'(R - 1)) phase <= '0;
      else                     phase <= phase + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold <= '0;
    end else if (take) begin
      hold <= in_data;
    end
  end

  // A missed slot repeats the last accepted sample.
  assign xs = in_valid ? in_data : hold;

  always_comb begin
    cin[0] = {{GROWTH{xs[WIDTH-1]}}, xs};
    for (int i = 0; i < N; i++) begin
      cin[i+1] = cin[i] - dly[i][M-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < M; k++) begin
          dly[i][k] <= '0;
        end
      end
    end else if (slot) begin
      for (int i = 0; i < N; i++) begin
        dly[i][0] <= cin[i];
        for (int k = 1; k < M; k++) begin
          dly[i][k] <= dly[i][k-1];
        end
      end
    end
  end

  assign u = slot ? cin[N] : '0;

  always_comb begin
    nxt[0] = integ[0] + u;
    for (int i = 1; i < N; i++) begin
      nxt[i] = integ[i] + integ[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        integ[i] <= '0;
      end
    end else if (clk_en) begin
      for (int i = 0; i < N; i++) begin
        integ[i] <= nxt[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= clk_en;
    end
  end

  // Set beats clear when both land on the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      underrun <= 1'b0;
    end else if (slot && !in_valid) begin
      underrun <= 1'b1;
    end else if (underrun_clr) begin
      underrun <= 1'b0;
    end
  end

`ifdef CIC_INTERP_NORM_EN
  localparam logic signed [OUT_W:0] HALF =
    (OUT_W+1)'(1) <<< (GROWTH - 1);
  localparam logic signed [OUT_W:0] MAXV =
    (OUT_W+1)'((1 << (WIDTH - 1)) - 1);
  localparam logic signed [OUT_W:0] MINV = ~MAXV;

  logic signed [OUT_W:0] rnd;
  logic signed [OUT_W:0] shf;
  logic [WIDTH-1:0]      sat;
  logic [WIDTH-1:0]      out_q;

  // One extra bit so the rounding offset cannot overflow.
  always_comb begin
    rnd = {nxt[N-1][OUT_W-1], nxt[N-1]} + HALF;
    shf = rnd >>> GROWTH;
    sat = shf[WIDTH-1:0];
    if (shf > MAXV) begin
      sat = MAXV[WIDTH-1:0];
    end else if (shf < MINV) begin
      sat = MINV[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q <= '0;
    end else if (clk_en) begin
      out_q <= sat;
    end
  end

  assign out_data = out_q;
`else
  assign out_data = integ[N-1];
`endif

endmodule

// File: doc/cic_interp.md
Name: cic_interp

Overview:
- Parametrised N-stage CIC interpolator: comb chain at input rate, zero-stuffing upsampler by R, integrator chain at output rate.
- Successor to the fixed single-stage comb/integrator pair; adds stage count N, differential delay M, an internal rate counter and an input valid/ready handshake.
- Sits between sin_gen (or any signed sample source) and the delta-sigma modulator.
- Output rate is set by an external clk_en strobe from clk_div.

Parameters:
- WIDTH, 16, signed input sample width.
- R, 100, interpolation ratio, >= 2.
- M, 1, differential delay, 1 or 2.
- N, 3, number of comb and integrator stages, 1..6.
- GROWTH, N*$clog2(R*M), bit growth (derived; do not override).
- OUT_W, WIDTH+GROWTH, output width (derived).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- clk_en  in  1  output-rate strobe, one clk cycle wide; called a "tick" below.
- in_data  in  WIDTH  signed input sample.
- in_valid  in  1  in_data valid; upstream holds in_data until accepted.
- in_ready  out  1  block accepts a sample this cycle.
- out_data  out  OUT_W  signed output; with CIC_INTERP_NORM_EN, WIDTH bits wide.
- out_valid  out  1  one-cycle pulse when out_data updates.
- underrun  out  1  sticky flag: an accept slot passed with no valid input.
- underrun_clr  in  1  synchronous clear of underrun.

Behaviour:
- Reset (rst=0, async): phase counter=0; all comb delay registers and integrator registers=0; hold register=0; out_data=0; out_valid=0; underrun=0; in_ready=0.
- Phase counter: 0..R-1, advances only on ticks, wraps R-1 -> 0. No state changes between ticks, except underrun_clr.
- Accept slot: the tick with phase==0. in_ready = clk_en && phase==0, combinational. Transfer occurs when in_valid && in_ready.
- Comb input x:
  - in_data on transfer; the hold register loads in_data at the same time.
  - On an accept slot with in_valid=0, x = hold register (ZOH repeat) and underrun sets on that tick.
- Comb chain: stage i is y_i = y_{i-1} - y_{i-1}[n-M]. Delay registers (M deep per stage) update only on accept slots. The adder chain is combinational from x, so there is no comb latency.
- Upsampler: integrator-1 input = comb output on accept-slot ticks, 0 on all other ticks.
- Integrators: N registered stages, each updates on every tick. Arithmetic is two's complement in OUT_W bits with modular wrap (no saturation); this is correct by construction for GROWTH.
- Output:
  - out_data = integrator-N register.
  - Latency: a sample accepted on tick k first appears in out_data after tick k+N-1.
  - out_valid = registered clk_en, high the cycle after each tick.
- DC gain = (R*M)^N / R. With N=1, M=1 the output is a pure zero-order hold of the input.
- underrun_clr and a new underrun on the same cycle: set wins.
- Reset mid-operation: immediate clear of all state. The first accept slot after release is the first tick.
- Sign extension: in_data is sign-extended to OUT_W before the comb chain.

Optional Feature:
- Macro: CIC_INTERP_NORM_EN.
- Defined: out_data is WIDTH bits. The value is integrator-N >> GROWTH, rounded half-up (add 1<<(GROWTH-1) before the shift), then saturated to the signed WIDTH range. Still registered; no added latency.
- Undefined: out_data is the full OUT_W raw integrator value.

Test Plan:
- Reset hold: rst=0 for 3 cycles with ticks running -> out_data=0, in_ready=0, underrun=0; first in_ready on the first tick after release.
- ZOH impulse (N=1, R=4, M=1, clk_en every 5 clk): accept 100, then zeros -> out_data=100 for exactly 4 ticks starting after the accept tick, then 0.
- DC gain (N=2, R=4, M=1): constant in_data=1000 with valid always high -> out_data settles to 4000 within 3 input periods and stays exactly 4000.
- Underrun (N=1, R=4): accept 500, then drop in_valid for one slot -> out_data stays 500, underrun=1; underrun_clr pulse -> underrun=0.
- Negative full-scale and wrap (N=3, R=100, M=1): constant -32768 -> settled out_data = -32768*10000, no spurious wrap. With CIC_INTERP_NORM_EN -> -32768*10000/2^21 rounded, i.e. -156.
- Mid-stream reset: assert rst during the ramp of a 1000-count DC input -> all outputs 0 immediately; after release the ramp repeats cycle-identically to the first run.
